// File: rtl/collision_scheduler_if.sv
// collision_scheduler_if
//   Bundles the frame/request inputs, the updater handshake and the
//   scheduler status outputs of collision_scheduler.
//   master : the side that produces frame ticks, requests and the updater
//            handshake (testbench / surrounding game logic).
//   slave  : collision_scheduler itself.
//   Signals:
//     frame_tick  one-cycle pulse per video frame
//     coll_req    pair hits (bit0 = 1-2, bit1 = 1-3, bit2 = 2-3)
//     upd_ready   updater can accept a grant
//     upd_done    updater finished the current pair (one-cycle pulse)
//     FLAG        ball flags for the granted pair, 3'b000 when idle
//     upd_valid   grant valid
//     busy        a grant is being offered or serviced
//     pending     latched, unserviced pair requests
//     err         sticky watchdog flag
interface collision_scheduler_if;
    logic       frame_tick;
    logic [2:0] coll_req;
    logic       upd_ready;
    logic       upd_done;
    logic [2:0] FLAG;
    logic       upd_valid;
    logic       busy;
    logic [2:0] pending;
    logic       err;

    modport master (
        output frame_tick, coll_req, upd_ready, upd_done,
        input  FLAG, upd_valid, busy, pending, err
    );

    modport slave (
        input  frame_tick, coll_req, upd_ready, upd_done,
        output FLAG, upd_valid, busy, pending, err
    );
endinterface

// File: rtl/collision_scheduler.sv
// collision_scheduler
//   Arbitrates pairwise ball-collision events among three balls and hands
//   them one pair at a time to the shared collision-direction updater.
//   Requests are latched on frame_tick, granted round-robin, masked for
//   COOLDOWN frames after service, and guarded by a handshake watchdog.
//   Ports:
//     clk   system clock
//     rst   synchronous, active-low reset
//     bus   collision_scheduler_if.slave (requests, updater handshake, status)
//   Optional feature (macro COLL_SCHED_STATS_EN):
//     stat_12, stat_13, stat_23  saturating per-pair completion counters
//     stat_drop                  saturating count of cooldown-masked requests
module collision_scheduler #(
    parameter int COOLDOWN = 4,
    parameter int CD_W     = 3,
    parameter int TIMEOUT  = 255,
    parameter int TO_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    collision_scheduler_if.slave  bus
`ifdef COLL_SCHED_STATS_EN
    ,
    output logic [7:0]            stat_12,
    output logic [7:0]            stat_13,
    output logic [7:0]            stat_23,
    output logic [7:0]            stat_drop
`endif
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
    // Abandon at the edge that closes the TIMEOUT-th clock spent in WAIT_DONE.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t          state_r, state_nxt_s;
    logic [1:0]      grant_r, grant_nxt_s, last_grant_r;
    logic [2:0]      pending_r, pending_nxt_s;
    logic [CD_W-1:0] cd_r [3];
    logic [TO_W-1:0] wd_r;
    logic            err_r;
    logic [2:0]      flag_r, flag_nxt_s;
    logic            valid_r, valid_nxt_s;
    logic            busy_r, busy_nxt_s;
    logic [2:0]      cool_mask_s, inflight_s, grant_oh_s;
    logic            done_s, tmo_s, finish_s;

    // First set request searching cyclically from last+1 (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
        logic [1:0] pick;
        case (last)
            2'd0:    pick = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            2'd1:    pick = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
            default: pick = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
        endcase
        return pick;
    endfunction

    function automatic logic [2:0] pair_flag(input logic [1:0] pair);
        logic [2:0] f;
        case (pair)
            2'd0:    f = 3'b011;
            2'd1:    f = 3'b101;
            2'd2:    f = 3'b110;
            default: f = 3'b000;
        endcase
        return f;
    endfunction

    function automatic logic [2:0] pair_onehot(input logic [1:0] pair);
        logic [2:0] oh;
        case (pair)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Masks and completion decode shared by the FSM and the datapath.
    always_comb begin
        cool_mask_s = {(cd_r[2] != {CD_W{1'b0}}), (cd_r[1] != {CD_W{1'b0}}), (cd_r[0] != {CD_W{1'b0}})};
        grant_oh_s  = pair_onehot(grant_r);
        if (state_r != ST_IDLE) begin
            inflight_s = grant_oh_s;
        end else begin
            inflight_s = 3'b000;
        end
        done_s   = (state_r == ST_WAIT_DONE) && bus.upd_done;
        tmo_s    = (state_r == ST_WAIT_DONE) && !bus.upd_done && (wd_r == TO_LAST);
        finish_s = done_s || tmo_s;
    end

    // Pending update: the completing pair is cleared, and the latch uses the
    // pre-completion inflight mask so it cannot be re-latched the same frame.
    always_comb begin
        pending_nxt_s = pending_r;
        if (finish_s) begin
            pending_nxt_s = pending_nxt_s & ~grant_oh_s;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (bus.frame_tick) begin
            pending_nxt_s = pending_nxt_s | (bus.coll_req & ~cool_mask_s & ~inflight_s);
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and grant selection.
    always_comb begin
        state_nxt_s = state_r;
        grant_nxt_s = grant_r;
        case (state_r)
            ST_IDLE: begin
                if (pending_r != 3'b000) begin
                    state_nxt_s = ST_ISSUE;
                    grant_nxt_s = rr_pick(pending_r, last_grant_r);
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (valid_r && bus.upd_ready) begin
                    state_nxt_s = ST_WAIT_DONE;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_WAIT_DONE: begin
                if (finish_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the next state so they can be registered.
    always_comb begin
        flag_nxt_s  = 3'b000;
        valid_nxt_s = 1'b0;
        busy_nxt_s  = 1'b0;
        case (state_nxt_s)
            ST_IDLE: begin
                flag_nxt_s  = 3'b000;
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
            ST_ISSUE: begin
                flag_nxt_s  = pair_flag(grant_nxt_s);
                valid_nxt_s = 1'b1;
                busy_nxt_s  = 1'b1;
            end
            ST_WAIT_DONE: begin
                flag_nxt_s  = pair_flag(grant_nxt_s);
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b1;
            end
            default: begin
                flag_nxt_s  = 3'b000;
                valid_nxt_s = 1'b0;
                busy_nxt_s  = 1'b0;
            end
        endcase
    end

    // Grant bookkeeping, watchdog, sticky error and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_r      <= 2'd0;
            last_grant_r <= 2'd2;
            pending_r    <= 3'b000;
            wd_r         <= {TO_W{1'b0}};
            err_r        <= 1'b0;
            flag_r       <= 3'b000;
            valid_r      <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            grant_r   <= grant_nxt_s;
            pending_r <= pending_nxt_s;
            flag_r    <= flag_nxt_s;
            valid_r   <= valid_nxt_s;
            busy_r    <= busy_nxt_s;
            if (finish_s) begin
                last_grant_r <= grant_r;
            end
            if (tmo_s) begin
                err_r <= 1'b1;
            end
            // Counts clocks spent in WAIT_DONE; zero on entry.
            if (state_r == ST_WAIT_DONE) begin
                wd_r <= wd_r + {{(TO_W-1){1'b0}}, 1'b1};
            end else begin
                wd_r <= {TO_W{1'b0}};
            end
        end
    end

    // Per-pair cooldown: a completion load beats a same-cycle frame decrement.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst) begin
                cd_r[i] <= {CD_W{1'b0}};
            end else if (done_s && (grant_r == 2'(i))) begin
                cd_r[i] <= CD_LOAD;
            end else if (bus.frame_tick && (cd_r[i] != {CD_W{1'b0}})) begin
                cd_r[i] <= cd_r[i] - {{(CD_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.FLAG      = flag_r;
    assign bus.upd_valid = valid_r;
    assign bus.busy      = busy_r;
    assign bus.pending   = pending_r;
    assign bus.err       = err_r;

`ifdef COLL_SCHED_STATS_EN
    logic [7:0] stat_r [3];
    logic [7:0] stat_drop_r;
    logic [8:0] drop_sum_s;

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return 2'(v[0]) + 2'(v[1]) + 2'(v[2]);
    endfunction

    // Running drop count plus this frame's cooldown-masked requests.
    always_comb begin
        if (bus.frame_tick) begin
            drop_sum_s = {1'b0, stat_drop_r} + {7'd0, popcount3(bus.coll_req & cool_mask_s)};
        end else begin
            drop_sum_s = {1'b0, stat_drop_r};
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                stat_r[i] <= 8'd0;
            end
            stat_drop_r <= 8'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (done_s && (grant_r == 2'(i)) && (stat_r[i] != 8'hFF)) begin
                    stat_r[i] <= stat_r[i] + 8'd1;
                end
            end
            stat_drop_r <= drop_sum_s[8] ? 8'hFF : drop_sum_s[7:0];
        end
    end

    assign stat_12   = stat_r[0];
    assign stat_13   = stat_r[1];
    assign stat_23   = stat_r[2];
    assign stat_drop = stat_drop_r;
`else
    // Statistics counters are not built in this configuration.
`endif
endmodule

// File: tb/tb_collision_scheduler.sv
// tb_collision_scheduler
//   Directed scenarios followed by randomized traffic; every cycle the DUT
//   outputs are compared with a behavioural model of the scheduler rules.
module tb_collision_scheduler;
    localparam int COOLDOWN = 4;
    localparam int TIMEOUT  = 255;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    collision_scheduler_if bus ();

`ifdef COLL_SCHED_STATS_EN
    logic [7:0] stat_12, stat_13, stat_23, stat_drop;
`endif

    collision_scheduler #(
        .COOLDOWN(COOLDOWN), .CD_W(3), .TIMEOUT(TIMEOUT), .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef COLL_SCHED_STATS_EN
        , .stat_12(stat_12), .stat_13(stat_13), .stat_23(stat_23), .stat_drop(stat_drop)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: phase 0 = no grant, 1 = grant offered, 2 = awaiting done
    int       m_phase, m_pair, m_last, m_wait;
    bit [2:0] m_pend;
    int       m_cd [3];
    bit       m_err;
    int       m_stat [3];
    int       m_drop;

    bit       auto_done;
    logic [2:0] grants_q [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] flag_of(input int p);
        if (p == 0) return 3'b011;
        if (p == 1) return 3'b101;
        return 3'b110;
    endfunction

    // Advance the model by one clock edge using the inputs presently driven.
    task automatic model_step();
        bit fin_ok, fin;
        bit [2:0] add, old_pend;
        if (!rst) begin
            m_phase = 0; m_pair = 0; m_last = 2; m_wait = 0;
            m_pend = 3'b000; m_err = 1'b0; m_drop = 0;
            for (int i = 0; i < 3; i++) begin m_cd[i] = 0; m_stat[i] = 0; end
            return;
        end
        fin_ok   = (m_phase == 2) && bus.upd_done;
        fin      = fin_ok || ((m_phase == 2) && (m_wait + 1 == TIMEOUT));
        add      = 3'b000;
        old_pend = m_pend;
        if (bus.frame_tick) begin
            for (int i = 0; i < 3; i++) begin
                if (bus.coll_req[i]) begin
                    if (m_cd[i] != 0) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
                    else if (!(m_phase != 0 && m_pair == i)) add[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (fin_ok && m_pair == i) m_cd[i] = COOLDOWN;
            else if (bus.frame_tick && m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
        end
        if (fin) m_pend[m_pair] = 1'b0;
        m_pend = m_pend | add;
        case (m_phase)
            0: if (old_pend != 3'b000) begin
                for (int off = 3; off >= 1; off--) begin
                    if (old_pend[(m_last + off) % 3]) m_pair = (m_last + off) % 3;
                end
                m_phase = 1;
            end
            1: if (bus.upd_ready) begin m_phase = 2; m_wait = 0; end
            default: if (fin) begin
                if (fin_ok) m_stat[m_pair] = (m_stat[m_pair] < 255) ? m_stat[m_pair] + 1 : 255;
                else m_err = 1'b1;
                m_last = m_pair;
                m_phase = 0;
            end else begin
                m_wait++;
            end
        endcase
    endtask

    task automatic compare_outputs();
        check_value("FLAG", bus.FLAG, (m_phase != 0) ? flag_of(m_pair) : 3'b000);
        check_value("upd_valid", bus.upd_valid, m_phase == 1);
        check_value("busy", bus.busy, m_phase != 0);
        check_value("pending", bus.pending, m_pend);
        check_value("err", bus.err, m_err);
`ifdef COLL_SCHED_STATS_EN
        check_value("stat_12", stat_12, m_stat[0]);
        check_value("stat_13", stat_13, m_stat[1]);
        check_value("stat_23", stat_23, m_stat[2]);
        check_value("stat_drop", stat_drop, m_drop);
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_outputs();
    endtask

    // Clocks with an idealised updater: done in the first WAIT_DONE clock.
    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            bus.upd_done = auto_done && (m_phase == 2);
            if (m_phase == 1 && bus.upd_ready) grants_q.push_back(bus.FLAG);
            cycle();
            bus.upd_done = 1'b0;
        end
    endtask

    task automatic tick(input logic [2:0] req);
        bus.frame_tick = 1'b1;
        bus.coll_req   = req;
        step(1);
        bus.frame_tick = 1'b0;
        bus.coll_req   = 3'($urandom);
    endtask

    logic [2:0] t1_exp [3];

    initial begin
        t1_exp = '{3'b011, 3'b101, 3'b110};
        bus.frame_tick = 1'b0; bus.coll_req = 3'b000;
        bus.upd_ready = 1'b1; bus.upd_done = 1'b0;
        auto_done = 1'b1;

        // Reset
        rst = 1'b0;
        cycle(); cycle();
        rst = 1'b1;

        // All three pairs requested: round-robin from pair 1-2
        tick(3'b111);
        step(12);
        check_value("t1_ngrants", grants_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < grants_q.size()) check_value("t1_order", grants_q[i], t1_exp[i]);
        end
        check_value("t1_pend", bus.pending, 3'b000);

        // Cooldown masks the next four frames
        for (int k = 0; k < 4; k++) begin
            tick(3'b001);
            step(3);
            check_value("t2_masked", bus.busy, 1'b0);
        end
        bus.upd_ready = 1'b0;
        tick(3'b001);
        step(1);
        check_value("t2_grant", bus.FLAG, 3'b011);

        // Updater not ready: grant held steady
        for (int k = 0; k < 10; k++) begin
            check_value("t3_hold_v", bus.upd_valid, 1'b1);
            check_value("t3_hold_f", bus.FLAG, 3'b011);
            step(1);
        end
        bus.upd_ready = 1'b1;
        auto_done = 1'b0;
        step(1);
        check_value("t3_accept", bus.upd_valid, 1'b0);

        // Watchdog: no done for TIMEOUT clocks
        step(TIMEOUT - 1);
        check_value("t4_pre_err", bus.err, 1'b0);
        step(1);
        check_value("t4_err", bus.err, 1'b1);
        check_value("t4_idle", bus.busy, 1'b0);

        // Frame tick coinciding with completion of the same pair
        tick(3'b001);
        step(2);
        bus.frame_tick = 1'b1; bus.coll_req = 3'b001; bus.upd_done = 1'b1;
        cycle();
        bus.frame_tick = 1'b0; bus.upd_done = 1'b0;
        check_value("t5_pend", bus.pending, 3'b000);
        auto_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(3'b001);
            step(2);
            check_value("t5_masked", bus.busy, 1'b0);
        end
        tick(3'b001);
        step(4);

        // Reset while waiting for done
        auto_done = 1'b0;
        tick(3'b110);
        step(2);
        check_value("t6_waiting", bus.busy, 1'b1);
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        check_value("t6_rst_out", {bus.FLAG, bus.upd_valid, bus.busy, bus.pending, bus.err}, 9'd0);
        auto_done = 1'b1;
        tick(3'b111);
        step(1);
        check_value("t6_first", bus.FLAG, 3'b011);
        step(10);

        // Randomized traffic, with windows where the updater never finishes
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 499) != 0);
            bus.frame_tick = ($urandom_range(0, 5) == 0);
            bus.coll_req   = 3'($urandom);
            bus.upd_ready  = ($urandom_range(0, 9) < 7);
            if ((c % 1000) < 300) bus.upd_done = 1'b0;
            else bus.upd_done = ($urandom_range(0, 2) == 0);
            cycle();
        end
        rst = 1'b1;
        bus.frame_tick = 1'b0; bus.upd_done = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/collision_scheduler.md
Name: collision_scheduler

Overview:
- Arbitrates pairwise ball-collision events among the three balls and hands them, one pair at a time, to the shared collision-direction update unit.
- Latches collision requests once per frame and drives the updater's 3-bit ball FLAG with exactly two bits set.
- Applies round-robin fairness, a per-pair cooldown so overlapping balls do not re-trigger every frame, and a watchdog on the updater handshake.

Parameters:
- COOLDOWN, 4, frames a pair stays masked after it is serviced; must be less than 2^CD_W.
- CD_W, 3, cooldown counter width.
- TIMEOUT, 255, maximum clocks in WAIT_DONE before the grant is abandoned; must be less than 2^TO_W.
- TO_W, 8, watchdog counter width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- frame_tick  in  1  one-cycle pulse per video frame.
- coll_req  in  3  pair hits, sampled only on frame_tick: bit0 = balls 1-2, bit1 = balls 1-3, bit2 = balls 2-3.
- upd_ready  in  1  updater can accept a grant.
- upd_done  in  1  one-cycle pulse: updater finished the current pair.
- FLAG  out  3  ball flags to the updater: pair 1-2 = 3'b011, pair 1-3 = 3'b101, pair 2-3 = 3'b110; 3'b000 when no grant is active.
- upd_valid  out  1  grant valid.
- busy  out  1  high in ISSUE or WAIT_DONE.
- pending  out  3  latched, unserviced pair requests.
- err  out  1  sticky watchdog flag.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE.
  - FLAG=0, upd_valid=0, busy=0, pending=0, err=0.
  - All cooldown counters=0; last_grant=pair 2-3, so pair 1-2 has first priority.
  - Reset mid-operation drops any outstanding grant with no completion.
- Request latch, on frame_tick: pending |= coll_req & ~cool_mask & ~inflight.
  - cool_mask[i] = (cd[i] != 0).
  - inflight = the pair currently in ISSUE or WAIT_DONE.
- Cooldown decrement, on frame_tick: every nonzero cd[i] decrements by 1, saturating at 0.
  - A load (see WAIT_DONE) in the same cycle as a decrement wins: cd = COOLDOWN.
- States:
  - IDLE: if pending != 0, select the first set bit searching cyclically from last_grant+1 (order 0 -> 1 -> 2 -> 0). Register grant, drive FLAG and upd_valid=1 on the next cycle, go to ISSUE. Latency from pending set to upd_valid is 1 clk.
  - ISSUE: hold FLAG and upd_valid stable until upd_valid & upd_ready. On that edge go to WAIT_DONE, upd_valid=0, FLAG held, watchdog=0.
  - WAIT_DONE, upd_done: clear pending[grant], cd[grant]=COOLDOWN, last_grant=grant, FLAG=0, go to IDLE.
  - WAIT_DONE, watchdog reaches TIMEOUT: same as upd_done except cd is not loaded, and err=1 (sticky until reset).
  - upd_done outside WAIT_DONE is ignored.
- Back-to-back: at least one IDLE cycle between grants. Minimum grant period is 3 clks (IDLE, ISSUE with ready=1, WAIT_DONE with done=1).
- Simultaneous frame_tick and grant completion: the latch uses the pre-completion inflight mask, so the completing pair is not re-latched that frame. It is also masked afterwards by the cooldown load.
- Requests for a pair already pending merge (OR); there is no counting.

Optional Feature:
- Macro: COLL_SCHED_STATS_EN.
- Defined:
  - Adds outputs stat_12, stat_13, stat_23 (8 bits each): grants completed per pair via upd_done, saturating at 255, cleared by reset.
  - Adds output stat_drop (8 bits, saturating): counts requests masked by cooldown at frame_tick.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then frame_tick with coll_req=3'b111, upd_ready=1, upd_done 1 clk after accept -> FLAG sequence 011, 101, 110; pending goes 111 -> 110 -> 100 -> 000.
- After the above, coll_req=3'b001 on the next 4 frame_ticks -> no grant (cooldown 4). 5th frame_tick -> FLAG=011 granted.
- upd_ready=0 for 10 clks with a grant pending -> upd_valid and FLAG=011 held steady for 10 clks, accepted on the 11th.
- upd_done never asserted -> after 255 clks in WAIT_DONE, err=1, pending bit cleared, state IDLE, cd not loaded.
- frame_tick with coll_req=3'b001 on the same cycle as upd_done for pair 1-2 -> pending[0] stays 0 and cd[0]=4.
- rst=0 for 1 clk while in WAIT_DONE -> next cycle all outputs 0, the next grant starts from pair 1-2.
